mul16_seq: RTL and testbench

Sequential shift-add unsigned multiplier feeding the 16-bit adder datapath. Accepts two operands on a start strobe and performs one add/shift iteration per clock using an internal (WIDTH+1)-bit adder. Returns the full 2·WIDTH-bit product, its low word, and an overflow flag. Provides multiply for ALU/CPU stages that only have a single-cycle adder.

---
 rtl/mul16_seq_if.sv | 32 +++
 rtl/mul16_seq.sv | 102 ++++++++++
 tb/tb_mul16_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mul16_seq_if.sv
// Bundle of the multiplier's request/result signals, shared by the
// requester (master) and the multiplier (slave).
//
// Handshake: the master raises start with operands a/b valid in the same
// cycle; the multiplier accepts on the rising edge only when it is not busy
// (IDLE or DONE). start seen while busy is ignored. After acceptance busy
// stays high for WIDTH cycles, then done pulses for one cycle together with
// a fresh product/lo/ovf, which then hold until the next done pulse.
// state is a debug view of the controller state.
interface mul16_seq_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     lo;
  logic                 ovf;
  logic [1:0]           state;

  modport master (
    output start, a, b,
    input  busy, done, product, lo, ovf, state
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, lo, ovf, state
  );
endinterface

// File: rtl/mul16_seq.sv
// Sequential shift-add unsigned multiplier. One add/shift step per clock
// through a (WIDTH+1)-bit adder; WIDTH steps per product, no early exit.
module mul16_seq #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  mul16_seq_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   acc_hi_q;
  logic [WIDTH-1:0]   acc_lo_q;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] product_q;
  logic               ovf_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH:0]     sum_d;
  logic [WIDTH-1:0]   acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_d;
  logic [CW-1:0]      count_d;
  logic               last_d;

  // One iteration: conditional add of the multiplicand, then shift the
  // whole {carry, acc_hi, acc_lo} right by one so the carry is kept.
  always_comb begin
    sum_d    = {1'b0, acc_hi_q};
    if (acc_lo_q[0]) begin
      sum_d  = {1'b0, acc_hi_q} + {1'b0, mcand_q};
    end
    acc_hi_d = sum_d[WIDTH:1];
    acc_lo_d = {sum_d[0], acc_lo_q[WIDTH-1:1]};
    count_d  = count_q + CW'(1);
    last_d   = (count_q == CW'(WIDTH - 1));
  end

  // Controller and datapath registers; outputs are all registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            mcand_q  <= bus.a;
            acc_hi_q <= '0;
            acc_lo_q <= bus.b;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end else begin
            state_q  <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          count_q  <= count_d;
          if (last_d) begin
            product_q <= {acc_hi_d, acc_lo_d};
            ovf_q     <= |acc_hi_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.lo      = product_q[WIDTH-1:0];
  assign bus.ovf     = ovf_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_mul16_seq.sv
// Bench for mul16_seq: random and directed operands, expected products
// from plain multiplication, checked by a monitor as results appear.
module tb_mul16_seq;

  localparam int W = 16;
  localparam int LAT = W;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;
  bit   mon_en;

  logic [2*W-1:0] exp_q[$];
  int             exp_cyc_q[$];
  logic [2*W-1:0] last_prod;

  mul16_seq_if #(.WIDTH(W)) bus ();

  mul16_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    int g;
    g = 0;
    while (bus.busy && g < 40) begin
      @(negedge clk);
      g++;
    end
    check("issue_wait_idle", 64'(g >= 40), 64'd0);
    bus.start = 1'b1;
    bus.a = av;
    bus.b = bv;
    @(posedge clk);
    #1;
    exp_q.push_back((2*W)'(av) * (2*W)'(bv));
    exp_cyc_q.push_back(cyc + LAT);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (!bus.done && g < 40) begin
      @(negedge clk);
      g++;
    end
    check("wait_done_timeout", 64'(g >= 40), 64'd0);
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_product", 64'(bus.product), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    last_prod = '0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    int             ec;
    bit             exp_busy;
    if (mon_en && !reset) begin
      check("busy_done_exclusive", 64'(bus.busy & bus.done), 64'd0);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got product %0h expected no result (cycle %0d)",
                   bus.product, cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("product", 64'(bus.product), 64'(e));
          check("lo", 64'(bus.lo), 64'(e[W-1:0]));
          check("ovf", 64'(bus.ovf), 64'(e[2*W-1:W] != '0));
          check("latency_cycle", 64'(cyc), 64'(ec));
          last_prod = e;
        end
      end else begin
        exp_busy = (exp_cyc_q.size() > 0) && (cyc < exp_cyc_q[0]);
        check("busy", 64'(bus.busy), 64'(exp_busy));
        check("product_held", 64'(bus.product), 64'(last_prod));
        check("ovf_held", 64'(bus.ovf), 64'(last_prod[2*W-1:W] != '0));
      end
    end
  end

  // stimulus
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    total     = 0;
    bad       = 0;
    cyc       = 0;
    mon_en    = 1'b0;
    last_prod = '0;
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.a     = 16'h7;
    bus.b     = 16'h7;
    repeat (3) @(negedge clk);
    check("init_busy", 64'(bus.busy), 64'd0);
    check("init_done", 64'(bus.done), 64'd0);
    check("init_product", 64'(bus.product), 64'd0);
    check("init_lo", 64'(bus.lo), 64'd0);
    check("init_ovf", 64'(bus.ovf), 64'd0);
    bus.start = 1'b0;
    #2 reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // 3*5 with an ignored start pulse in the middle of RUN
    issue(16'd3, 16'd5);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.a = 16'd7;
    bus.b = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    @(negedge clk);

    // directed values, including full-scale and zero operands
    issue(16'h1080, 16'h0002);
    wait_done();
    @(negedge clk);
    issue(16'hFFFF, 16'hFFFF);
    wait_done();
    @(negedge clk);
    issue(16'h0000, 16'h1234);
    wait_done();
    @(negedge clk);
    issue(16'h1234, 16'h0000);
    wait_done();
    @(negedge clk);

    // back-to-back: new start presented in the DONE cycle
    issue(16'd3, 16'd5);
    wait_done();
    issue(16'h0100, 16'h0100);
    wait_done();
    @(negedge clk);

    // reset 8 cycles into a long operation, then a normal one
    issue(16'hFFFF, 16'hFFFF);
    repeat (7) @(negedge clk);
    do_reset_mid();
    issue(16'd2, 16'd2);
    wait_done();
    @(negedge clk);

    // random operands, random gaps (gap 0 means back-to-back)
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 5))
        0: ra = 16'hFFFF;
        1: rb = 16'h0001;
        2: ra = 16'h0000;
        default: ;
      endcase
      issue(ra, rb);
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
